// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes, write-path states and decode helpers shared by the AXI-Lite slave
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int ADDR_LSB = 2;
  typedef enum logic {W_COLLECT, W_RESP} wstate_e;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_lite_addr_decode.sv
// axi_lite_addr_decode: byte address to register index plus in-range flag
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM = 16,
  parameter int IDX_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  index,
  output logic              in_range
);
  logic [ADDR_W-1:0] word;
  assign word = addr >> ADDR_LSB;
  assign index = word[IDX_W-1:0];
  // every word-address bit above the index must be zero, and non-power-of-2 banks need the bound too
  assign in_range = ((word >> IDX_W) == '0) && (32'(index) < NUM);
endmodule

// File: rtl/axi_lite_slave_regfile.sv
// axi_lite_slave_regfile: AXI4-Lite slave exposing a bank of byte-strobed 32-bit control registers
module axi_lite_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_NUM_REGS = 16,
  localparam int IDX_W = idx_width(C_NUM_REGS)
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] o_regs,
  output logic                                     o_wr_valid,
  output logic [IDX_W-1:0]                         o_wr_index,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            o_wr_data
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  logic [DW-1:0] regs [C_NUM_REGS];
  wstate_e state, state_nx;
  logic aw_held, w_held, aw_ok, commit;
  logic [IDX_W-1:0] aw_idx;
  logic [DW-1:0] w_data, wr_merged;
  logic [SW-1:0] w_strb;
  logic [IDX_W-1:0] aw_dec_idx, ar_dec_idx;
  logic aw_dec_ok, ar_dec_ok, aw_hs, w_hs, ar_hs;
  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};
  axi_lite_addr_decode #(.ADDR_W(C_S_AXI_ADDR_WIDTH), .NUM(C_NUM_REGS), .IDX_W(IDX_W)) u_aw_dec (
    .addr(S_AXI_AWADDR), .index(aw_dec_idx), .in_range(aw_dec_ok)
  );
  axi_lite_addr_decode #(.ADDR_W(C_S_AXI_ADDR_WIDTH), .NUM(C_NUM_REGS), .IDX_W(IDX_W)) u_ar_dec (
    .addr(S_AXI_ARADDR), .index(ar_dec_idx), .in_range(ar_dec_ok)
  );
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  always_ff @(posedge S_AXI_ACLK)
    state <= S_AXI_ARESET ? W_COLLECT : state_nx;
  always_comb
    state_nx = (state == W_COLLECT) ? ((aw_held && w_held) ? W_RESP : W_COLLECT)
                                    : (S_AXI_BREADY ? W_COLLECT : W_RESP);
  always_comb begin
    S_AXI_AWREADY = !S_AXI_ARESET && state == W_COLLECT && !aw_held;
    S_AXI_WREADY = !S_AXI_ARESET && state == W_COLLECT && !w_held;
    S_AXI_BVALID = state == W_RESP;
    commit = state == W_COLLECT && aw_held && w_held;
  end
  always_comb begin
    wr_merged = regs[aw_idx];
    for (int b = 0; b < SW; b++)
      if (w_strb[b]) wr_merged[8*b +: 8] = w_data[8*b +: 8];
  end
  always_ff @(posedge S_AXI_ACLK)
    if (S_AXI_ARESET) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      aw_ok <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
      S_AXI_BRESP <= RESP_OKAY;
      o_wr_valid <= 1'b0;
      o_wr_index <= '0;
      o_wr_data <= '0;
      for (int k = 0; k < C_NUM_REGS; k++) regs[k] <= '0;
    end else begin
      o_wr_valid <= commit && aw_ok;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx <= aw_dec_idx;
        aw_ok <= aw_dec_ok;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        S_AXI_BRESP <= aw_ok ? RESP_OKAY : RESP_SLVERR;
        if (aw_ok) begin
          regs[aw_idx] <= wr_merged;
          o_wr_index <= aw_idx;
          o_wr_data <= wr_merged;
        end
      end
    end
  assign S_AXI_ARREADY = !S_AXI_ARESET && !S_AXI_RVALID;
  // reads sample the bank before any same-edge commit lands
  always_ff @(posedge S_AXI_ACLK)
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA <= ar_dec_ok ? regs[ar_dec_idx] : '0;
      S_AXI_RRESP <= ar_dec_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
    assign o_regs[k*DW +: DW] = regs[k];
  end
endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// tb_axi_lite_slave_regfile: directed plus randomized checks against an array model of the register bank
module tb_axi_lite_slave_regfile;
  localparam int NREG = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [2:0] awprot = '0, arprot = '0;
  logic [3:0] wstrb = '0;
  logic awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic arvalid = 1'b0, arready, rvalid, rready = 1'b0;
  logic [1:0] bresp, rresp;
  logic [NREG*32-1:0] o_regs;
  logic o_wr_valid;
  logic [3:0] o_wr_index;
  logic [31:0] o_wr_data;
  logic [31:0] model [NREG];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  axi_lite_slave_regfile dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .o_regs(o_regs), .o_wr_valid(o_wr_valid), .o_wr_index(o_wr_index), .o_wr_data(o_wr_data)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_regs(input string tag);
    for (int k = 0; k < NREG; k++) check(tag, o_regs[k*32 +: 32], model[k]);
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction
  function automatic bit in_range(input logic [31:0] a);
    return (a >> 2) < NREG;
  endfunction
  task automatic write_hs(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int cyc = 0;
    awaddr = a;
    wdata = d;
    wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid = !w_done && cyc >= w_dly;
      aw_now = awvalid && awready;
      w_now = wvalid && wready;
      step();
      aw_done |= aw_now;
      w_done |= w_now;
      cyc++;
      if (w_done && !aw_done) check("wready_low_after_w", 32'(wready), 0);
      if (aw_done && !w_done) check("awready_low_after_aw", 32'(awready), 0);
    end
    awvalid = 0;
    wvalid = 0;
    check("write_hs_timeout", 32'(aw_done && w_done), 1);
  endtask
  task automatic write_resp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    bit ok = in_range(a);
    int idx = int'(a >> 2);
    logic [31:0] nv = ok ? merge(model[idx], d, s) : '0;
    logic [1:0] er = ok ? 2'b00 : 2'b10;
    step();
    check("bvalid_set", 32'(bvalid), 1);
    check("bresp", 32'(bresp), 32'(er));
    check("wr_valid_pulse", 32'(o_wr_valid), 32'(ok));
    if (ok) begin
      check("wr_index", 32'(o_wr_index), idx);
      check("wr_data", o_wr_data, nv);
      model[idx] = nv;
    end
    check("awready_in_resp", 32'(awready), 0);
    check("wready_in_resp", 32'(wready), 0);
    check_regs("regs_after_write");
    for (int h = 0; h < hold; h++) begin
      step();
      check("bvalid_hold", 32'(bvalid), 1);
      check("bresp_hold", 32'(bresp), 32'(er));
      check("wr_valid_one_cycle", 32'(o_wr_valid), 0);
      check("awready_hold", 32'(awready), 0);
    end
    bready = 1;
    step();
    bready = 0;
    check("bvalid_clear", 32'(bvalid), 0);
    check("wr_valid_after_b", 32'(o_wr_valid), 0);
    check("awready_back", 32'(awready), 1);
    check("wready_back", 32'(wready), 1);
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int aw_dly, input int w_dly, input int hold);
    write_hs(a, d, s, aw_dly, w_dly);
    write_resp(a, d, s, hold);
  endtask
  task automatic do_read(input logic [31:0] a, input int hold);
    bit ok = in_range(a);
    logic [31:0] ev = ok ? model[int'(a >> 2)] : '0;
    logic [1:0] er = ok ? 2'b00 : 2'b10;
    int cyc = 0;
    araddr = a;
    arvalid = 1;
    while (!arready && cyc < 20) begin
      step();
      cyc++;
    end
    check("arready_timeout", 32'(arready), 1);
    step();
    arvalid = 0;
    check("rvalid_set", 32'(rvalid), 1);
    check("rdata", rdata, ev);
    check("rresp", 32'(rresp), 32'(er));
    for (int h = 0; h < hold; h++) begin
      step();
      check("rvalid_hold", 32'(rvalid), 1);
      check("rdata_hold", rdata, ev);
      check("rresp_hold", 32'(rresp), 32'(er));
      check("arready_hold", 32'(arready), 0);
    end
    rready = 1;
    step();
    rready = 0;
    check("rvalid_clear", 32'(rvalid), 0);
    check("arready_back", 32'(arready), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a, d;
    logic [3:0] s;
    for (int k = 0; k < NREG; k++) model[k] = '0;
    step();
    step();
    check("rst_awready_low", 32'(awready), 0);
    check("rst_arready_low", 32'(arready), 0);
    rst = 0;
    step();
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_bresp", 32'(bresp), 0);
    check("rst_rresp", 32'(rresp), 0);
    check("rst_rdata", rdata, 0);
    check("rst_wr_valid", 32'(o_wr_valid), 0);
    check("rst_wr_data", o_wr_data, 0);
    check("idle_awready", 32'(awready), 1);
    check("idle_wready", 32'(wready), 1);
    check("idle_arready", 32'(arready), 1);
    check_regs("rst_regs");
    do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h8, 0);
    do_write(32'h4, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(32'h4, 32'h11223344, 4'h5, 3, 0, 0);
    check("strobe_merge", o_regs[32 +: 32], 32'hAA22CC44);
    do_write(32'h6, 32'h12345678, 4'h0, 0, 2, 0);
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_read(32'h1000, 0);
    do_write(32'h14, 32'hCAFEF00D, 4'hF, 1, 0, 5);
    do_read(32'h14, 5);
    do_write(32'hC, 32'h1, 4'hF, 0, 0, 0);
    awaddr = 32'hC;
    wdata = 32'h2;
    wstrb = 4'hF;
    awvalid = 1;
    wvalid = 1;
    step();
    awvalid = 0;
    wvalid = 0;
    araddr = 32'hC;
    arvalid = 1;
    step();
    arvalid = 0;
    check("coll_rvalid", 32'(rvalid), 1);
    check("coll_rdata_old", rdata, 32'h1);
    check("coll_bvalid", 32'(bvalid), 1);
    check("coll_wr_valid", 32'(o_wr_valid), 1);
    model[3] = 32'h2;
    check_regs("coll_regs");
    bready = 1;
    rready = 1;
    step();
    bready = 0;
    rready = 0;
    check("coll_b_done", 32'(bvalid), 0);
    check("coll_r_done", 32'(rvalid), 0);
    do_read(32'hC, 0);
    write_hs(32'h10, 32'h55, 4'hF, 0, 0);
    step();
    araddr = 32'h8;
    arvalid = 1;
    step();
    arvalid = 0;
    check("pre_rst_bvalid", 32'(bvalid), 1);
    check("pre_rst_rvalid", 32'(rvalid), 1);
    rst = 1;
    step();
    check("mid_rst_bvalid", 32'(bvalid), 0);
    check("mid_rst_rvalid", 32'(rvalid), 0);
    check("mid_rst_awready", 32'(awready), 0);
    check("mid_rst_wready", 32'(wready), 0);
    check("mid_rst_arready", 32'(arready), 0);
    for (int k = 0; k < NREG; k++) model[k] = '0;
    check_regs("mid_rst_regs");
    rst = 0;
    step();
    check("post_rst_bvalid", 32'(bvalid), 0);
    check("post_rst_rvalid", 32'(rvalid), 0);
    do_write(32'h3C, 32'h0BADC0DE, 4'hF, 0, 1, 0);
    do_read(32'h3C, 0);
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a | 32'h100;
      d = $urandom;
      s = 4'($urandom);
      do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      a = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
      do_read(a, $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_lite_slave_regfile.md
# axi_lite_slave_regfile

AXI4-Lite responder that terminates the bus from our AXI-Lite master and exposes a bank of read/write 32-bit control registers. It accepts the address and data channels independently, applies byte strobes, returns OKAY/SLVERR responses, and presents register contents and a per-write notification to user logic. It sits at the far end of the master's bus in the control-plane fabric.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 32, byte address width.
- C_NUM_REGS, 16, register count, 1..256; IDX_W = max(1, clog2(C_NUM_REGS)).
- S_AXI_ACLK  in  1  single clock, all logic on its rising edge.
- S_AXI_ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR in ADDR; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in DATA; S_AXI_WSTRB in DATA/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR in ADDR; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out DATA; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
- o_regs  out  C_NUM_REGS*DATA  flattened register contents; reg k at [k*DATA +: DATA].
- o_wr_valid  out  1  one-cycle pulse per committed in-range write.
- o_wr_index  out  IDX_W  index of that write.
- o_wr_data  out  DATA  post-strobe register value of that write.

## Operation
- Decode: index = addr[2 +: IDX_W]; addr[1:0] ignored. In range iff all bits above addr[1:0] equal index zero-extended and index < C_NUM_REGS. Otherwise SLVERR (2'b10), else OKAY (2'b00).
- Write path states: W_COLLECT, W_RESP.
  - W_COLLECT: AWREADY = !aw_held; WREADY = !w_held. Each handshake latches its payload and sets its held flag; AW and W may arrive in either order or in the same cycle.
  - When both flags are set: commit on the next edge. In range: byte i of reg[index] <= WDATA byte i where WSTRB[i]=1; o_wr_valid pulses. Out of range: no register change, no pulse. BVALID <= 1, BRESP set, flags cleared, go to W_RESP.
  - W_RESP: AWREADY = WREADY = 0; BVALID held with stable BRESP until BREADY; return to W_COLLECT on the edge BVALID&BREADY.
  - WSTRB = 0 in range: OKAY, register unchanged, o_wr_valid still pulses with the unchanged value.
- Read path: ARREADY = !RVALID. On the AR handshake edge: RDATA <= reg[index] (0 if out of range), RRESP set, RVALID <= 1. Hold until RREADY; clear on that edge.
- Read and write paths are independent; reads are never stalled by writes.

## Timing
- Reset (S_AXI_ARESET high at an edge): all registers 0, o_regs 0, BVALID/RVALID/o_wr_valid 0, BRESP/RRESP 00, RDATA 0, o_wr_index/o_wr_data 0, held flags cleared, state W_COLLECT. AWREADY/WREADY/ARREADY are forced 0 while reset is high.
- Reset mid-transaction: in-flight latched AW/W and pending B/R are dropped silently; no response is ever issued for them.
- Write latency: the last of AW/W handshakes at edge E; register, o_regs, o_wr_* and BVALID all update at E+1. If BREADY is high, B completes at E+2 and AWREADY/WREADY return high after E+2. Peak throughput: 1 write per 3 cycles.
- Read latency: AR handshake at edge E; RVALID/RDATA valid after E. With RREADY held high, 1 read per 2 cycles.
- A write commit and an AR handshake at the same edge to the same register: the read returns the pre-write value.
- o_wr_valid is exactly one cycle wide, coincident with the first BVALID cycle.
- No combinational path from any input to any output other than the reset gating of the READY signals.

## Structure
- Package axi_lite_pkg: RESP_OKAY, RESP_SLVERR constants; write-state enum {W_COLLECT, W_RESP}; ADDR_LSB = 2.
- Sub-module axi_lite_addr_decode (combinational): address -> {index, in_range}. It is instantiated twice, once for AW and once for AR.
- Register bank, write FSM and read channel live in the top module.

## Test plan
- AW and W in the same cycle, addr 0x8, data 0xDEADBEEF, strb 0xF -> reg2 = 0xDEADBEEF at E+1, o_wr_valid pulse with index 2, BRESP 00; a read of 0x8 returns 0xDEADBEEF with RRESP 00.
- W three cycles before AW (addr 0x4, data 0x11223344, strb 0x5) over reg1 = 0xAABBCCDD -> reg1 = 0xAA22CC44; WREADY stays low after the W handshake until B completes.
- Out of range: write to 0x40 with C_NUM_REGS = 16 -> BRESP 10, no o_wr_valid pulse, no register change; read of 0x1000 -> RDATA 0, RRESP 10.
- Backpressure: BREADY/RREADY held low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY/WREADY/ARREADY stay low; exactly one completion each.
- Collision: write commit to reg3 (old value 0x1, new value 0x2) on the same edge as an AR of 0xC -> RDATA 0x1; a subsequent read returns 0x2.
- Reset asserted while BVALID = 1 and RVALID = 1 -> both 0 the next cycle, all registers 0, no B or R handshake issued; a new write completes normally after reset.
